// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared widths, the long-unit FIFO entry layout and a register decode helper
// used by the RF writeback scheduler.
package rf_wb_scoreboard_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } lu_entry_t;

  // One-hot register select; x0 never maps to a scoreboard bit.
  function automatic logic [NUM_REGS-1:0] reg_dec(input logic [REG_AW-1:0] r);
    reg_dec = '0;
    if (r != REG_X0) reg_dec[r] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_wb_scoreboard_sync_fifo.sv
// Synchronous FIFO for long-unit results; no fall-through, registered
// full/empty flags, head read straight out of the storage registers.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push) count_d = count_d + 1'b1;
    if (do_pop)  count_d = count_d - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port scheduler: ALU writeback has priority, long-unit
// results queue in a FIFO, and a scoreboard stalls issue on hazards.
module rf_wb_scoreboard
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int LU_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] issue_rs1_i,
  input  logic [REG_AW-1:0] issue_rs2_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic              issue_rd_we_i,
  input  logic              issue_long_i,
  output logic              issue_stall_o,
  input  logic              alu_wb_valid_i,
  input  logic [REG_AW-1:0] alu_wb_addr_i,
  input  logic [XLEN-1:0]   alu_wb_data_i,
  input  logic              lu_wb_valid_i,
  input  logic [REG_AW-1:0] lu_wb_addr_i,
  input  logic [XLEN-1:0]   lu_wb_data_i,
  output logic              lu_wb_ready_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_w_addr_o,
  output logic [XLEN-1:0]   rf_w_data_o
);

  localparam int OW = $clog2(LU_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  lu_entry_t           head;
  logic                fifo_full, fifo_empty;
  logic                push, drain, accept_long;
  logic [NUM_REGS-1:0] pending_q, pending_d, clr_now, set_now, pend_eff;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                h_raw, h_waw, h_cap, h_starve;

  sync_fifo #(
    .WIDTH (REG_AW + XLEN),
    .DEPTH (LU_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({lu_wb_addr_i, lu_wb_data_i}),
    .pop_i   (drain),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign lu_wb_ready_o = rst_i | ~fifo_full;
  assign push          = lu_wb_valid_i & ~fifo_full & ~rst_i;
  assign drain         = ~rst_i & ~alu_wb_valid_i & ~fifo_empty;

  always_comb begin
    rf_we_o     = 1'b0;
    rf_w_addr_o = '0;
    rf_w_data_o = '0;
    if (!rst_i) begin
      if (alu_wb_valid_i) begin
        rf_we_o     = 1'b1;
        rf_w_addr_o = alu_wb_addr_i;
        rf_w_data_o = alu_wb_data_i;
      end else if (!fifo_empty) begin
        rf_we_o     = 1'b1;
        rf_w_addr_o = head.addr;
        rf_w_data_o = head.data;
      end
    end
  end

  // The RF bypasses its write data to same-cycle reads, so a register being
  // drained right now is already safe to read or overwrite.
  assign clr_now  = drain ? reg_dec(head.addr) : '0;
  assign pend_eff = pending_q & ~clr_now;

  assign h_raw    = pend_eff[issue_rs1_i] | pend_eff[issue_rs2_i];
  assign h_waw    = issue_rd_we_i & pend_eff[issue_rd_i];
  assign h_cap    = issue_long_i & (outstanding_q == OW'(LU_DEPTH)) & ~drain;
  assign h_starve = (starve_q == SW'(STARVE_LIMIT));

  assign issue_stall_o = ~rst_i & issue_valid_i & (h_raw | h_waw | h_cap | h_starve);
  assign accept_long   = ~rst_i & issue_valid_i & ~issue_stall_o & issue_long_i & issue_rd_we_i;

  assign set_now   = accept_long ? reg_dec(issue_rd_i) : '0;
  assign pending_d = (pending_q & ~clr_now) | set_now;

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept_long && !drain)      outstanding_d = outstanding_q + 1'b1;
    else if (!accept_long && drain) outstanding_d = outstanding_q - 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || drain)
      starve_d = '0;
    else if (alu_wb_valid_i && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      starve_q      <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      starve_q      <= starve_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(lu_wb_valid_i && fifo_full));
  a_no_drain_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(drain && outstanding_q == '0));

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Randomized scoreboard bench for rf_wb_scoreboard with a queue-based
// reference model of the long unit, result FIFO and issue hazards.
module tb_rf_wb_scoreboard;

  localparam int LU_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int N_CYCLES     = 4000;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_rd_we, issue_long, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        alu_wb_valid, lu_wb_valid, lu_wb_ready;
  logic [4:0]  alu_wb_addr, lu_wb_addr, rf_w_addr;
  logic [31:0] alu_wb_data, lu_wb_data, rf_w_data;
  logic        rf_we;

  rf_wb_scoreboard #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_rs1_i    (issue_rs1),
    .issue_rs2_i    (issue_rs2),
    .issue_rd_i     (issue_rd),
    .issue_rd_we_i  (issue_rd_we),
    .issue_long_i   (issue_long),
    .issue_stall_o  (issue_stall),
    .alu_wb_valid_i (alu_wb_valid),
    .alu_wb_addr_i  (alu_wb_addr),
    .alu_wb_data_i  (alu_wb_data),
    .lu_wb_valid_i  (lu_wb_valid),
    .lu_wb_addr_i   (lu_wb_addr),
    .lu_wb_data_i   (lu_wb_data),
    .lu_wb_ready_o  (lu_wb_ready),
    .rf_we_o        (rf_we),
    .rf_w_addr_o    (rf_w_addr),
    .rf_w_data_o    (rf_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        ready;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } lu_op_t;

  exp_t   exp_q[$];
  lu_op_t lu_q[$];   // issued long ops whose result has not been offered yet
  lu_op_t mfifo[$];  // results waiting for the RF port
  int     starve;
  int     tests, fails;
  bit     done;

  // A register is busy while any in-flight long op targets it, minus the one
  // whose result is being written this very cycle.
  function automatic bit busy(input int r, input bit drn, input int head_addr);
    int n;
    n = 0;
    if (r == 0) return 1'b0;
    foreach (lu_q[i])  if (int'(lu_q[i].addr) == r)  n++;
    foreach (mfifo[i]) if (int'(mfifo[i].addr) == r) n++;
    if (drn && head_addr == r) n--;
    return n > 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    tests = 0;
    fails = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_we", 32'(rf_we), 32'(e.we));
        if (e.we) begin
          check("rf_w_addr", 32'(rf_w_addr), 32'(e.addr));
          check("rf_w_data", rf_w_data, e.data);
        end
        check("issue_stall", 32'(issue_stall), 32'(e.stall));
        check("lu_wb_ready", 32'(lu_wb_ready), 32'(e.ready));
      end
    end
  end

  // Driver + reference model.
  initial begin
    exp_t   e;
    lu_op_t op;
    bit     have_instr, drn, stall_exp;
    int     p_alu, head_addr, outstanding;

    done = 0;
    rst = 1'b1;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_rd_we = 0; issue_long = 0;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lu_wb_valid = 0; lu_wb_addr = 0; lu_wb_data = 0;
    have_instr = 0;
    starve = 0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 3) || (cyc >= 2000 && cyc < 2003);

      case ((cyc / 40) % 4)
        0: p_alu = 30;
        1: p_alu = 60;
        2: p_alu = 95;
        default: p_alu = 100;
      endcase
      alu_wb_valid = ($urandom_range(0, 99) < p_alu);
      alu_wb_addr  = 5'($urandom_range(0, 31));
      alu_wb_data  = $urandom;

      lu_wb_valid = (lu_q.size() > 0) && (lu_q.size() > 0 ? lu_q[0].due <= cyc : 1'b0);
      lu_wb_addr  = (lu_q.size() > 0) ? lu_q[0].addr : 5'd0;
      lu_wb_data  = (lu_q.size() > 0) ? lu_q[0].data : 32'd0;

      if (!have_instr && ($urandom_range(0, 3) != 0)) begin
        have_instr  = 1;
        issue_rs1   = 5'($urandom_range(0, 7));
        issue_rs2   = 5'($urandom_range(0, 7));
        issue_rd    = 5'($urandom_range(0, 7));
        issue_rd_we = ($urandom_range(0, 3) != 0);
        issue_long  = issue_rd_we && ($urandom_range(0, 1) == 1);
      end
      issue_valid = have_instr;

      if (rst) begin
        e.we = 0; e.addr = 0; e.data = 0; e.stall = 0; e.ready = 1;
        exp_q.push_back(e);
        lu_q.delete();
        mfifo.delete();
        starve = 0;
        have_instr = 0;
        continue;
      end

      drn       = !alu_wb_valid && (mfifo.size() > 0);
      head_addr = (mfifo.size() > 0) ? int'(mfifo[0].addr) : -1;
      outstanding = lu_q.size() + mfifo.size();

      e.we    = alu_wb_valid || (mfifo.size() > 0);
      e.addr  = alu_wb_valid ? alu_wb_addr : (mfifo.size() > 0 ? mfifo[0].addr : 5'd0);
      e.data  = alu_wb_valid ? alu_wb_data : (mfifo.size() > 0 ? mfifo[0].data : 32'd0);
      e.ready = (mfifo.size() < LU_DEPTH);
      stall_exp = issue_valid && (
                    busy(int'(issue_rs1), drn, head_addr) ||
                    busy(int'(issue_rs2), drn, head_addr) ||
                    (issue_rd_we && busy(int'(issue_rd), drn, head_addr)) ||
                    (issue_long && outstanding == LU_DEPTH && !drn) ||
                    (starve == STARVE_LIMIT));
      e.stall = stall_exp;
      exp_q.push_back(e);

      if ((mfifo.size() > 0) && alu_wb_valid)
        starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
      else
        starve = 0;
      if (drn) void'(mfifo.pop_front());
      if (lu_wb_valid) mfifo.push_back(lu_q.pop_front());
      if (issue_valid && !stall_exp) begin
        if (issue_long) begin
          op.addr = issue_rd;
          op.data = $urandom;
          op.due  = cyc + 1 + $urandom_range(0, 12);
          lu_q.push_back(op);
        end
        have_instr = 0;
      end
    end

    @(posedge clk);
    #1;
    issue_valid = 0;
    alu_wb_valid = 0;
    lu_wb_valid = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL exp_q_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
